// File: rtl/aes_pkg.sv
// Shared AES types for the SubBytes/ShiftRows stage: state geometry, FSM encoding and S-box tables.
// The inverse table is only referenced when SUB_SHIFT_INV_EN is defined.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_shift_rows_if.sv
// Input/output state handshakes for sub_shift_rows; mode_inv exists only with SUB_SHIFT_INV_EN.
// master drives states in and consumes results, slave is the stage itself.
interface sub_shift_rows_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in;
    logic   out_valid;
    logic   out_ready;
    state_t out;

`ifdef SUB_SHIFT_INV_EN
    logic   mode_inv;

    modport master (output in_valid, in, mode_inv, out_ready,
                    input  in_ready, out_valid, out);
    modport slave  (input  in_valid, in, mode_inv, out_ready,
                    output in_ready, out_valid, out);
`else
    modport master (output in_valid, in, out_ready,
                    input  in_ready, out_valid, out);
    modport slave  (input  in_valid, in, out_ready,
                    output in_ready, out_valid, out);
`endif

endinterface

// File: rtl/aes_sbox.sv
// One-byte combinational S-box lane; with SUB_SHIFT_INV_EN an inverse select picks the inverse table.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
`ifdef SUB_SHIFT_INV_EN
    input  logic       inv_i,
`endif
    output logic [7:0] byte_o
);

`ifdef SUB_SHIFT_INV_EN
    assign byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];
`else
    assign byte_o = SBOX[byte_i];
`endif

endmodule

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes+ShiftRows: one output column per cycle through four shared S-box lanes.
// SUB_SHIFT_INV_EN adds a per-state inverse transform selected by mode_inv at input handshake.
//
// state | meaning
// IDLE  | waiting for a state, in_ready=1
// BUSY  | substituting column col_q, one column per cycle
// DONE  | out holds the finished state, out_valid=1
module sub_shift_rows
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    sub_shift_rows_if.slave bus
);

    fsm_t            state_q, state_d;
    logic [1:0]      col_q, col_d;
    state_t          data_q, data_d;
    state_t          out_q, out_d;
    logic [3:0][7:0] lane_sub;
    logic            accept;
`ifdef SUB_SHIFT_INV_EN
    logic            mode_q, mode_d;
`endif

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (col_q == 2'd3) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        bus.out_valid = (state_q == DONE);
    end

    // Lane r reads the byte its row rotation brings into column col_q.
    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [1:0] src_col;
`ifdef SUB_SHIFT_INV_EN
        assign src_col = mode_q ? (col_q - 2'(lane)) : (col_q + 2'(lane));
        aes_sbox u_sbox (
            .byte_i (data_q[lane][src_col]),
            .inv_i  (mode_q),
            .byte_o (lane_sub[lane])
        );
`else
        assign src_col = col_q + 2'(lane);
        aes_sbox u_sbox (
            .byte_i (data_q[lane][src_col]),
            .byte_o (lane_sub[lane])
        );
`endif
    end

    always_comb begin
        data_d = data_q;
        col_d  = col_q;
        out_d  = out_q;
`ifdef SUB_SHIFT_INV_EN
        mode_d = mode_q;
`endif
        if (accept) begin
            data_d = bus.in;
            col_d  = 2'd0;
`ifdef SUB_SHIFT_INV_EN
            mode_d = bus.mode_inv;
`endif
        end else if (state_q == BUSY) begin
            for (int r = 0; r < 4; r++) out_d[r][col_q] = lane_sub[r];
            col_d = col_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            col_q  <= 2'd0;
            out_q  <= '0;
`ifdef SUB_SHIFT_INV_EN
            mode_q <= 1'b0;
`endif
        end else begin
            data_q <= data_d;
            col_q  <= col_d;
            out_q  <= out_d;
`ifdef SUB_SHIFT_INV_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Scoreboard bench for sub_shift_rows: expected states are queued at input acceptance and checked
// by an independent monitor; the reference S-box is derived from GF(2^8) arithmetic.
module tb_sub_shift_rows;
    import aes_pkg::*;

    typedef struct {
        state_t data;
        int     t_acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sub_shift_rows_if bus ();

    sub_shift_rows dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [7:0] ref_s  [256];
    logic [7:0] ref_si [256];
    bit         prev_v = 1'b0;
    bit         rand_ready = 1'b0;
    bit         cur_inv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic state_t ref_xform(state_t s, bit inv);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = inv ? ref_si[s[r][(c - r + 4) % 4]] : ref_s[s[r][(c + r) % 4]];
        return o;
    endfunction

    // Bytes listed column by column, top row first.
    function automatic state_t from_cols(logic [127:0] v);
        state_t s;
        for (int k = 0; k < 16; k++) s[k % 4][k / 4] = v[127 - 8 * k -: 8];
        return s;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom_range(0, 255));
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input state_t s, input state_t exp);
        int n;
        n = 0;
        bus.in       = s;
        bus.in_valid = 1'b1;
`ifdef SUB_SHIFT_INV_EN
        bus.mode_inv = cur_inv;
`endif
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
        end else begin
            exp_q.push_back('{data: exp, t_acc: cyc + 1});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d states still pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", bus.out);
                end else begin
                    chk("latency", 128'(cyc - exp_q[0].t_acc), 128'd4);
                end
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                chk("out_data", bus.out, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            prev_v = bus.out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        state_t     fips_in, fips_out, s1, s2;
        logic [7:0] binv;
        logic [7:0] b;
        int         n;

        for (int x = 0; x < 256; x++) begin
            binv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) binv = 8'(y);
            b = binv;
            ref_s[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) ref_si[ref_s[x]] = 8'(x);

        fips_in  = from_cols(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
        fips_out = from_cols(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b1;
`ifdef SUB_SHIFT_INV_EN
        bus.mode_inv  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_out", bus.out, 128'd0);
        @(posedge clk);
        #1;

        send(fips_in, fips_out);
        drain();
        send(from_cols({16{8'h00}}), from_cols({16{8'h63}}));
        drain();
        send(from_cols({16{8'h53}}), from_cols({16{8'hed}}));
        drain();

        // Reset two cycles into BUSY: nothing may be flagged afterwards.
        s1 = rand_state();
        send(s1, ref_xform(s1, 1'b0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out", bus.out, 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_quiet", 128'(bus.out_valid), 128'd0);
        end
        @(posedge clk);
        #1;

        // in_valid pulses during BUSY must be dropped.
        s1 = rand_state();
        s2 = rand_state();
        send(s1, ref_xform(s1, 1'b0));
        bus.in       = s2;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("busy_in_ready", 128'(bus.in_ready), 128'd0);
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
        drain();
        repeat (8) @(posedge clk);
        #1;

        // Backpressure in DONE, then back-to-back capture on release.
        bus.out_ready = 1'b0;
        s1 = rand_state();
        send(s1, ref_xform(s1, 1'b0));
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 128'(bus.out_valid), 128'd1);
        repeat (10) begin
            chk("bp_out_stable", bus.out, ref_xform(s1, 1'b0));
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        s2 = rand_state();
        send(s2, ref_xform(s2, 1'b0));
        drain();

`ifdef SUB_SHIFT_INV_EN
        cur_inv = 1'b1;
        send(fips_out, fips_in);
        drain();
        cur_inv = 1'b0;
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
`ifdef SUB_SHIFT_INV_EN
            cur_inv = 1'($urandom_range(0, 1));
`endif
            s1 = rand_state();
            send(s1, ref_xform(s1, cur_inv));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        drain();
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
